// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin arbiter that shares one ALU.
// A grant issues the winner's command and operands to the ALU. A two-stage
// tag pipeline follows each operation, so the registered ALU result goes back
// to the requester that issued it. Commands above 8 never reach the ALU and
// get an error response with the same latency as a legal operation.
//
// Handshake: a requester raises x_req with x_cmd/x_da/x_db stable and holds
// them until it sees the one-cycle x_gnt pulse. While x_gnt is high the
// request is ignored, so back-to-back grants to one requester are impossible.
// Responses have no ready signal: rsp_vld_x pulses for exactly one cycle
// exactly two cycles after x_gnt, and the requester must take it then.
module alu_arb #(
  parameter int I_BW = 4,
  parameter int D_BW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic [I_BW-1:0] a_cmd,
  input  logic [D_BW-1:0] a_da,
  input  logic [D_BW-1:0] a_db,
  output logic            a_gnt,
  input  logic            b_req,
  input  logic [I_BW-1:0] b_cmd,
  input  logic [D_BW-1:0] b_da,
  input  logic [D_BW-1:0] b_db,
  output logic            b_gnt,
  output logic            alu_en,
  output logic [I_BW-1:0] alu_cmd,
  output logic [D_BW-1:0] alu_da,
  output logic [D_BW-1:0] alu_db,
  input  logic            alu_o_en,
  input  logic            alu_o_of,
  input  logic            alu_o_ofb,
  input  logic [D_BW-1:0] alu_o_dat,
  output logic            rsp_vld_a,
  output logic            rsp_vld_b,
  output logic [D_BW-1:0] rsp_dat,
  output logic            rsp_of,
  output logic            rsp_ofb,
  output logic            rsp_err
);

  // Round-robin pointer states: which requester wins a collision.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  // Requester id carried in the tag pipeline.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Highest command the ALU implements.
  localparam logic [I_BW-1:0] CMD_MAX = I_BW'(8);

  logic            rr;
  logic            elig_a;
  logic            elig_b;
  logic            grant_a;
  logic            grant_b;
  logic            any_grant;
  logic [I_BW-1:0] win_cmd;
  logic [D_BW-1:0] win_da;
  logic [D_BW-1:0] win_db;
  logic            cmd_legal;

  logic            tag1_vld;
  logic            tag1_id;
  logic            tag1_err;
  logic            tag2_vld;
  logic            tag2_id;
  logic            tag2_err;

  // The ALU's own valid output is not needed: the tag pipeline alone routes results.
  logic            unused_alu_o_en;
  assign unused_alu_o_en = alu_o_en;

  // Eligibility and round-robin selection for this edge.
  always_comb begin
    elig_a    = a_req & ~a_gnt;
    elig_b    = b_req & ~b_gnt;
    grant_a   = elig_a & (~elig_b | (rr == RR_A));
    grant_b   = elig_b & (~elig_a | (rr == RR_B));
    any_grant = grant_a | grant_b;
  end

  // Mux the winner's command and operands and screen illegal commands.
  always_comb begin
    win_cmd = a_cmd;
    win_da  = a_da;
    win_db  = a_db;
    if (grant_b) begin
      win_cmd = b_cmd;
      win_da  = b_da;
      win_db  = b_db;
    end
    cmd_legal = (win_cmd <= CMD_MAX);
  end

  // Arbitration state, grant pulses, ALU issue registers and tag stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= RR_A;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      alu_en   <= 1'b0;
      alu_cmd  <= '0;
      alu_da   <= '0;
      alu_db   <= '0;
      tag1_vld <= 1'b0;
      tag1_id  <= ID_A;
      tag1_err <= 1'b0;
    end else begin
      a_gnt    <= grant_a;
      b_gnt    <= grant_b;
      tag1_vld <= any_grant;
      if (any_grant) begin
        rr       <= grant_a ? RR_B : RR_A;
        alu_en   <= cmd_legal;
        alu_cmd  <= win_cmd;
        alu_da   <= win_da;
        alu_db   <= win_db;
        tag1_id  <= grant_b ? ID_B : ID_A;
        tag1_err <= ~cmd_legal;
      end else begin
        alu_en   <= 1'b0;
      end
    end
  end

  // Tag stage 2 lines up with the ALU output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag2_vld <= 1'b0;
      tag2_id  <= ID_A;
      tag2_err <= 1'b0;
    end else begin
      tag2_vld <= tag1_vld;
      tag2_id  <= tag1_id;
      tag2_err <= tag1_err;
    end
  end

  // Response strobes and data; data and flags hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_a <= 1'b0;
      rsp_vld_b <= 1'b0;
      rsp_dat   <= '0;
      rsp_of    <= 1'b0;
      rsp_ofb   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_vld_a <= tag2_vld & (tag2_id == ID_A);
      rsp_vld_b <= tag2_vld & (tag2_id == ID_B);
      if (tag2_vld) begin
        if (tag2_err) begin
          rsp_dat <= '0;
          rsp_of  <= 1'b0;
          rsp_ofb <= 1'b0;
          rsp_err <= 1'b1;
        end else begin
          rsp_dat <= alu_o_dat;
          rsp_of  <= alu_o_of;
          rsp_ofb <= alu_o_ofb;
          rsp_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed scenarios plus random traffic for alu_arb, checked
// every cycle against a transaction-level model (grant choice, issue record,
// queue of responses due two cycles later).
module tb_alu_arb;

  localparam int I_BW = 4;
  localparam int D_BW = 4;
  localparam int W    = 8;   // packed expected response {id, err, of, ofb, dat}

  logic            clk;
  logic            rst_n;
  logic            a_req, b_req;
  logic [I_BW-1:0] a_cmd, b_cmd;
  logic [D_BW-1:0] a_da, a_db, b_da, b_db;
  logic            a_gnt, b_gnt;
  logic            alu_en;
  logic [I_BW-1:0] alu_cmd;
  logic [D_BW-1:0] alu_da, alu_db;
  logic            alu_o_en, alu_o_of, alu_o_ofb;
  logic [D_BW-1:0] alu_o_dat;
  logic            rsp_vld_a, rsp_vld_b;
  logic [D_BW-1:0] rsp_dat;
  logic            rsp_of, rsp_ofb, rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arb #(.I_BW(I_BW), .D_BW(D_BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_cmd(a_cmd), .a_da(a_da), .a_db(a_db), .a_gnt(a_gnt),
    .b_req(b_req), .b_cmd(b_cmd), .b_da(b_da), .b_db(b_db), .b_gnt(b_gnt),
    .alu_en(alu_en), .alu_cmd(alu_cmd), .alu_da(alu_da), .alu_db(alu_db),
    .alu_o_en(alu_o_en), .alu_o_of(alu_o_of), .alu_o_ofb(alu_o_ofb), .alu_o_dat(alu_o_dat),
    .rsp_vld_a(rsp_vld_a), .rsp_vld_b(rsp_vld_b), .rsp_dat(rsp_dat),
    .rsp_of(rsp_of), .rsp_ofb(rsp_ofb), .rsp_err(rsp_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU stand-in: {of, ofb, dat} ----------------
  function automatic logic [5:0] alu_ref(input logic [3:0] c, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] s;
    logic [5:0] r;
    r = 6'd0;
    case (c)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = (s > 5'd15) ? {2'b10, 4'd15} : {2'b00, s[3:0]};
      end
      4'd1: r = (x >= y) ? {2'b00, x - y} : {2'b11, y - x};
      4'd2: r = {2'b00, x & y};
      4'd3: r = {2'b00, x | y};
      4'd4: r = {2'b00, x ^ y};
      4'd5: r = {2'b00, ~x};
      4'd6: r = {x[3], 1'b0, x[2:0], 1'b0};
      4'd7: r = {1'b0, x[0], 1'b0, x[3:1]};
      4'd8: r = (x == 4'd15) ? {2'b10, 4'd15} : {2'b00, x + 4'd1};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_o_en  <= 1'b0;
      alu_o_of  <= 1'b0;
      alu_o_ofb <= 1'b0;
      alu_o_dat <= '0;
    end else begin
      alu_o_en <= alu_en;
      if (alu_en) {alu_o_of, alu_o_ofb, alu_o_dat} <= alu_ref(alu_cmd, alu_da, alu_db);
    end
  end

  // ---------------- behavioural model ----------------
  logic            m_a_gnt, m_b_gnt, m_alu_en;
  logic [I_BW-1:0] m_alu_cmd;
  logic [D_BW-1:0] m_alu_da, m_alu_db;
  logic            m_rsp_a, m_rsp_b, m_rsp_of, m_rsp_ofb, m_rsp_err;
  logic [D_BW-1:0] m_rsp_dat;
  logic            fav_a;
  int              cyc;
  logic [W-1:0]    exp_q[$];
  int              due_q[$];

  task automatic m_reset();
    m_a_gnt = 0; m_b_gnt = 0; m_alu_en = 0;
    m_alu_cmd = '0; m_alu_da = '0; m_alu_db = '0;
    m_rsp_a = 0; m_rsp_b = 0; m_rsp_of = 0; m_rsp_ofb = 0; m_rsp_err = 0; m_rsp_dat = '0;
    fav_a = 1'b1;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic m_step();
    logic ea, eb, take_b, legal;
    logic [W-1:0] e;
    logic [3:0] cmd, da, db;
    logic [5:0] res;
    int d;
    cyc++;
    m_rsp_a = 0;
    m_rsp_b = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      d = due_q.pop_front();
      e = exp_q.pop_front();
      if (e[7]) m_rsp_b = 1; else m_rsp_a = 1;
      m_rsp_err = e[6];
      m_rsp_of  = e[5];
      m_rsp_ofb = e[4];
      m_rsp_dat = e[3:0];
    end
    ea = a_req && !m_a_gnt;
    eb = b_req && !m_b_gnt;
    take_b = (ea && eb) ? !fav_a : eb;
    m_a_gnt = (ea || eb) && !take_b;
    m_b_gnt = (ea || eb) && take_b;
    if (ea || eb) begin
      cmd = take_b ? b_cmd : a_cmd;
      da  = take_b ? b_da  : a_da;
      db  = take_b ? b_db  : a_db;
      legal = (cmd <= 4'd8);
      m_alu_en = legal;
      m_alu_cmd = cmd; m_alu_da = da; m_alu_db = db;
      fav_a = take_b;
      res = legal ? alu_ref(cmd, da, db) : 6'd0;
      exp_q.push_back({take_b, !legal, res});
      due_q.push_back(cyc + 2);
    end else begin
      m_alu_en = 0;
    end
  endtask

  initial begin
    cyc = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_gnt",     32'(a_gnt),     32'(m_a_gnt));
    chk("b_gnt",     32'(b_gnt),     32'(m_b_gnt));
    chk("alu_en",    32'(alu_en),    32'(m_alu_en));
    chk("alu_cmd",   32'(alu_cmd),   32'(m_alu_cmd));
    chk("alu_da",    32'(alu_da),    32'(m_alu_da));
    chk("alu_db",    32'(alu_db),    32'(m_alu_db));
    chk("rsp_vld_a", 32'(rsp_vld_a), 32'(m_rsp_a));
    chk("rsp_vld_b", 32'(rsp_vld_b), 32'(m_rsp_b));
    chk("rsp_dat",   32'(rsp_dat),   32'(m_rsp_dat));
    chk("rsp_of",    32'(rsp_of),    32'(m_rsp_of));
    chk("rsp_ofb",   32'(rsp_ofb),   32'(m_rsp_ofb));
    chk("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
    chk("rsp_excl",  32'(rsp_vld_a & rsp_vld_b), 32'(0));
  end

  // ---------------- driver tasks ----------------
  task automatic set_a(input logic r, input logic [3:0] c, input logic [3:0] x, input logic [3:0] y);
    a_req = r; a_cmd = c; a_da = x; a_db = y;
  endtask

  task automatic set_b(input logic r, input logic [3:0] c, input logic [3:0] x, input logic [3:0] y);
    b_req = r; b_cmd = c; b_da = x; b_db = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_cmd();
    return ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 32'(0));
    chk("rst_alu_en", 32'(alu_en), 32'(0));
    chk("rst_rsp_dat", 32'(rsp_dat), 32'(0));
    rst_n = 1;
    @(negedge clk);

    // single A ADD 3+4
    set_a(1, 4'd0, 4'd3, 4'd4);
    @(negedge clk);
    chk("t1_a_gnt", 32'(a_gnt), 32'(1));
    chk("t1_b_gnt", 32'(b_gnt), 32'(0));
    chk("t1_alu_en", 32'(alu_en), 32'(1));
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_rsp_a", 32'(rsp_vld_a), 32'(1));
    chk("t1_rsp_b", 32'(rsp_vld_b), 32'(0));
    chk("t1_dat", 32'(rsp_dat), 32'(7));
    chk("t1_flags", 32'({rsp_of, rsp_ofb, rsp_err}), 32'(0));
    drain(2);

    // contention after reset: A,B,A,B
    do_reset();
    set_a(1, 4'd0, 4'd1, 4'd2);
    set_b(1, 4'd4, 4'd5, 4'd3);
    @(negedge clk);
    chk("t2_g1_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
    @(negedge clk);
    chk("t2_g2_b", 32'({a_gnt, b_gnt}), 32'(2'b01));
    chk("t2_en2", 32'(alu_en), 32'(1));
    @(negedge clk);
    chk("t2_g3_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
    chk("t2_en3", 32'(alu_en), 32'(1));
    chk("t2_rsp1_a", 32'({rsp_vld_a, rsp_vld_b}), 32'(2'b10));
    chk("t2_rsp1_dat", 32'(rsp_dat), 32'(3));
    @(negedge clk);
    chk("t2_g4_b", 32'({a_gnt, b_gnt}), 32'(2'b01));
    chk("t2_en4", 32'(alu_en), 32'(1));
    chk("t2_rsp2_b", 32'({rsp_vld_a, rsp_vld_b}), 32'(2'b01));
    chk("t2_rsp2_dat", 32'(rsp_dat), 32'(6));
    a_req = 0;
    b_req = 0;
    drain(3);

    // flags routed: B SUB 3-5, then A ADD 9+8
    set_b(1, 4'd1, 4'd3, 4'd5);
    @(negedge clk);
    chk("t3_b_gnt", 32'(b_gnt), 32'(1));
    b_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_rsp_b", 32'({rsp_vld_a, rsp_vld_b}), 32'(2'b01));
    chk("t3_b_res", 32'({rsp_of, rsp_ofb, rsp_dat}), 32'({2'b11, 4'd2}));
    set_a(1, 4'd0, 4'd9, 4'd8);
    @(negedge clk);
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_rsp_a", 32'({rsp_vld_a, rsp_vld_b}), 32'(2'b10));
    chk("t3_a_res", 32'({rsp_of, rsp_ofb, rsp_dat}), 32'({2'b10, 4'd15}));

    // illegal command
    set_a(1, 4'd12, 4'd7, 4'd7);
    @(negedge clk);
    chk("t4_a_gnt", 32'(a_gnt), 32'(1));
    chk("t4_alu_en", 32'(alu_en), 32'(0));
    a_req = 0;
    @(negedge clk);
    chk("t4_alu_en2", 32'(alu_en), 32'(0));
    @(negedge clk);
    chk("t4_rsp_a", 32'(rsp_vld_a), 32'(1));
    chk("t4_err", 32'({rsp_err, rsp_of, rsp_ofb, rsp_dat}), 32'({3'b100, 4'd0}));
    drain(2);

    // lone requester held: grants on alternate cycles
    set_a(1, 4'd2, 4'd6, 4'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_alt_gnt", 32'(a_gnt), 32'((i % 2) == 0));
    end
    a_req = 0;
    drain(3);

    // reset mid-flight, then collision favours A
    set_a(1, 4'd0, 4'd2, 4'd2);
    @(negedge clk);
    chk("t6_a_gnt", 32'(a_gnt), 32'(1));
    a_req = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_outs", 32'({a_gnt, b_gnt, alu_en, rsp_vld_a, rsp_vld_b, rsp_err}), 32'(0));
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'({rsp_vld_a, rsp_vld_b}), 32'(0));
    end
    set_a(1, 4'd3, 4'd1, 4'd8);
    set_b(1, 4'd3, 4'd2, 4'd4);
    @(negedge clk);
    chk("t6_coll_a", 32'({a_gnt, b_gnt}), 32'(2'b10));
    a_req = 0;
    @(negedge clk);
    chk("t6_then_b", 32'({a_gnt, b_gnt}), 32'(2'b01));
    b_req = 0;
    drain(3);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (a_req && a_gnt) begin
        if ($urandom_range(0, 3) == 0) set_a(1, rnd_cmd(), 4'($urandom), 4'($urandom));
        else a_req = 0;
      end else if (!a_req && $urandom_range(0, 2) != 0) begin
        set_a(1, rnd_cmd(), 4'($urandom), 4'($urandom));
      end
      if (b_req && b_gnt) begin
        if ($urandom_range(0, 3) == 0) set_b(1, rnd_cmd(), 4'($urandom), 4'($urandom));
        else b_req = 0;
      end else if (!b_req && $urandom_range(0, 2) != 0) begin
        set_b(1, rnd_cmd(), 4'($urandom), 4'($urandom));
      end
    end
    @(negedge clk);
    a_req = 0;
    b_req = 0;
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
